multdiv_issue_ctrl: RTL and testbench

//  Initiator side of the multicycle mult/div handshake: accepts one op from the execute stage, pulses

---
 rtl/multdiv_pkg.sv | 19 +
 rtl/multdiv_watchdog.sv | 31 +++
 rtl/multdiv_issue_ctrl.sv | 130 +++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the multicycle mult/div issue controller: state encoding,
// op-select constants and default widths.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int WIDTH_DEF   = 32;
  localparam int TAG_W_DEF   = 5;
  localparam int TIMEOUT_DEF = 48;

endpackage

// File: rtl/multdiv_watchdog.sv
// WAIT-state watchdog, instantiated only when MULTDIV_TIMEOUT_EN is defined.
// o_expired fires in the TIMEOUT_CYCLES-th consecutive enabled cycle after a clear.
module multdiv_watchdog #(
  parameter int TIMEOUT_CYCLES = 48
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;
  logic          w_at_limit;

  assign w_at_limit = (r_count == LAST);
  assign o_expired  = i_enable & w_at_limit;

  // Saturates at the limit so a held enable cannot wrap the counter.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_at_limit) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Initiator side of the multicycle mult/div handshake: IDLE -> ISSUE -> WAIT -> RESP.
// Optional WAIT watchdog is enabled by defining MULTDIV_TIMEOUT_EN.
module multdiv_issue_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH          = WIDTH_DEF,
  parameter int TAG_W          = TAG_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_is_div,
  input  logic [WIDTH-1:0] req_opA,
  input  logic [WIDTH-1:0] req_opB,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_ready,
  output logic             md_ctrl_MULT,
  output logic             md_ctrl_DIV,
  output logic [WIDTH-1:0] md_operandA,
  output logic [WIDTH-1:0] md_operandB,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_exception,
  input  logic             md_resultRDY,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_exception,
  output logic [TAG_W-1:0] rsp_tag,
  input  logic             rsp_ready,
  output logic             busy,
  output state_t           dbg_state
);

  // Handshakes: a transfer happens in any cycle where valid & ready are both 1 at
  // the clock edge; valid never waits on ready, and a producer holds its payload
  // stable while valid=1 and ready=0.

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rst_done;
  logic             r_is_div;
  logic [TAG_W-1:0] r_tag;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_exc;
  logic [TAG_W-1:0] r_rsp_tag;
  logic             w_accept;
  logic             w_done;
  logic             w_timeout;

`ifdef MULTDIV_TIMEOUT_EN
  multdiv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_clear  (r_state == ST_ISSUE),
    .i_enable (r_state == ST_WAIT),
    .o_expired(w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // r_rst_done holds req_ready low for the first cycle after reset releases.
  assign req_ready = r_rst_done &
                     ((r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready));
  assign w_accept  = req_valid & req_ready;
  // RDY is only meaningful in WAIT; stale pulses elsewhere are dropped here.
  assign w_done    = (r_state == ST_WAIT) & (md_resultRDY | w_timeout);

  assign md_ctrl_MULT  = (r_state == ST_ISSUE) && (r_is_div == OP_MULT);
  assign md_ctrl_DIV   = (r_state == ST_ISSUE) && (r_is_div == OP_DIV);
  assign md_operandA   = r_opA;
  assign md_operandB   = r_opB;
  assign rsp_valid     = (r_state == ST_RESP);
  assign rsp_result    = r_rsp_result;
  assign rsp_exception = r_rsp_exc;
  assign rsp_tag       = r_rsp_tag;
  assign busy          = (r_state != ST_IDLE);
  assign dbg_state     = r_state;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (w_done) w_state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) w_state_nxt = w_accept ? ST_ISSUE : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operands/tag load only on accept, which cannot occur in ISSUE or WAIT.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rst_done   <= 1'b0;
      r_is_div     <= OP_MULT;
      r_tag        <= '0;
      r_opA        <= '0;
      r_opB        <= '0;
      r_rsp_result <= '0;
      r_rsp_exc    <= 1'b0;
      r_rsp_tag    <= '0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_accept) begin
        r_is_div <= req_is_div;
        r_tag    <= req_tag;
        r_opA    <= req_opA;
        r_opB    <= req_opB;
      end
      if (w_done) begin
        r_rsp_result <= md_resultRDY ? md_result : '0;
        r_rsp_exc    <= md_resultRDY ? md_exception : 1'b1;
        r_rsp_tag    <= r_tag;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl with an inline behavioural mult/div responder.
// Define MULTDIV_TIMEOUT_EN to also exercise the watchdog path.
module tb_multdiv_issue_ctrl;
  import multdiv_pkg::*;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_is_div;
  logic [W-1:0]  req_opA;
  logic [W-1:0]  req_opB;
  logic [TW-1:0] req_tag;
  logic          req_ready;
  logic          md_ctrl_MULT;
  logic          md_ctrl_DIV;
  logic [W-1:0]  md_operandA;
  logic [W-1:0]  md_operandB;
  logic [W-1:0]  md_result;
  logic          md_exception;
  logic          md_resultRDY;
  logic          rsp_valid;
  logic [W-1:0]  rsp_result;
  logic          rsp_exception;
  logic [TW-1:0] rsp_tag;
  logic          rsp_ready;
  logic          busy;
  state_t        dbg_state;

  int checks = 0;
  int errors = 0;
  int n_mult = 0;
  int n_div  = 0;

  logic [W-1:0] cur_a;
  logic [W-1:0] cur_b;
  logic         cur_div;
  int           m0;
  int           d0;
  logic [W-1:0] held_res;

  multdiv_issue_ctrl #(.WIDTH(W), .TAG_W(TW), .TIMEOUT_CYCLES(48)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_is_div   (req_is_div),
    .req_opA      (req_opA),
    .req_opB      (req_opB),
    .req_tag      (req_tag),
    .req_ready    (req_ready),
    .md_ctrl_MULT (md_ctrl_MULT),
    .md_ctrl_DIV  (md_ctrl_DIV),
    .md_operandA  (md_operandA),
    .md_operandB  (md_operandB),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_resultRDY (md_resultRDY),
    .rsp_valid    (rsp_valid),
    .rsp_result   (rsp_result),
    .rsp_exception(rsp_exception),
    .rsp_tag      (rsp_tag),
    .rsp_ready    (rsp_ready),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // Clock / reset block
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (md_ctrl_MULT === 1'b1) n_mult++;
    if (md_ctrl_DIV === 1'b1) n_div++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents an op in IDLE and steps into ISSUE; leaves the bench at the ISSUE cycle.
  task automatic start_op(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] tag);
    req_is_div = is_div;
    req_opA    = a;
    req_opB    = b;
    req_tag    = tag;
    req_valid  = 1'b1;
    cur_a = a;
    cur_b = b;
    cur_div = is_div;
    m0 = n_mult;
    d0 = n_div;
    #1;
    check("accept_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    check("issue_state", dbg_state, ST_ISSUE);
    check("issue_pulse", {md_ctrl_DIV, md_ctrl_MULT}, is_div ? 2'b10 : 2'b01);
    check("issue_busy", busy, 1'b1);
  endtask

  // From the ISSUE cycle: N cycles later the responder raises RDY for one cycle.
  task automatic finish_op(input int n, input logic [W-1:0] exp_res, input logic exp_exc,
                           input logic [TW-1:0] exp_tag);
    for (int i = 0; i < n; i++) begin
      tick();
      req_opA = $urandom;
      req_opB = $urandom;
      req_tag = TW'($urandom_range(0, 31));
      check("hold_opA", md_operandA, cur_a);
      check("hold_opB", md_operandB, cur_b);
      check("wait_no_rsp", rsp_valid, 1'b0);
    end
    md_result    = cur_div ? ((cur_b == 0) ? '0 : cur_a / cur_b) : cur_a * cur_b;
    md_exception = cur_div && (cur_b == 0);
    md_resultRDY = 1'b1;
    tick();
    md_resultRDY = 1'b0;
    md_result    = $urandom;
    md_exception = 1'b0;
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_result", rsp_result, exp_res);
    check("rsp_exception", rsp_exception, exp_exc);
    check("rsp_tag", rsp_tag, exp_tag);
    check("single_mult_pulse", n_mult - m0, cur_div ? 0 : 1);
    check("single_div_pulse", n_div - d0, cur_div ? 1 : 0);
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("release_busy", busy, 1'b0);
    check("release_rsp_valid", rsp_valid, 1'b0);
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_is_div   = 1'b0;
    req_opA      = '0;
    req_opB      = '0;
    req_tag      = '0;
    md_result    = '0;
    md_exception = 1'b0;
    md_resultRDY = 1'b0;
    rsp_ready    = 1'b0;

    // Reset state
    tick();
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_pulses", {md_ctrl_MULT, md_ctrl_DIV}, 2'b00);
    check("rst_opA", md_operandA, 32'h0);
    tick();
    reset = 1'b0;
    check("rst_rel_ready_low", req_ready, 1'b0);
    tick();
    check("rst_rel_ready_high", req_ready, 1'b1);

    // 1: div 101/3, tag 7, N=33 -> 33 at T+35
    start_op(OP_DIV, 32'd101, 32'd3, 5'd7);
    finish_op(33, 32'd33, 1'b0, 5'd7);
    release_rsp();

    // 2: mult 7 x -6, N=32 -> 0xFFFFFFD6
    start_op(OP_MULT, 32'd7, 32'hFFFF_FFFA, 5'd12);
    finish_op(32, 32'hFFFF_FFD6, 1'b0, 5'd12);
    release_rsp();

    // 3: div by zero flagged by the unit
    start_op(OP_DIV, 32'd5, 32'd0, 5'd1);
    finish_op(4, 32'd0, 1'b1, 5'd1);
    release_rsp();

    // 4: response back-pressure with a pending request, then back-to-back accept
    start_op(OP_MULT, 32'd12, 32'd11, 5'd3);
    finish_op(3, 32'd132, 1'b0, 5'd3);
    req_is_div = OP_DIV;
    req_opA    = 32'd100;
    req_opB    = 32'd7;
    req_tag    = 5'd9;
    req_valid  = 1'b1;
    m0 = n_mult;
    d0 = n_div;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_result", rsp_result, 32'd132);
      check("bp_rsp_tag", rsp_tag, 5'd3);
      check("bp_req_ready", req_ready, 1'b0);
    end
    check("bp_no_pulse", (n_mult - m0) + (n_div - d0), 0);
    rsp_ready = 1'b1;
    #1;
    check("b2b_req_ready", req_ready, 1'b1);
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    cur_a = 32'd100;
    cur_b = 32'd7;
    cur_div = OP_DIV;
    check("b2b_state", dbg_state, ST_ISSUE);
    check("b2b_div_pulse", md_ctrl_DIV, 1'b1);
    check("b2b_rsp_valid", rsp_valid, 1'b0);
    check("b2b_opA", md_operandA, 32'd100);
    finish_op(2, 32'd14, 1'b0, 5'd9);
    release_rsp();

    // 5: reset in WAIT, stale RDY afterwards is ignored
    start_op(OP_DIV, 32'd200, 32'd4, 5'd2);
    tick();
    tick();
    check("pre_rst_wait", dbg_state, ST_WAIT);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_pulses", {md_ctrl_MULT, md_ctrl_DIV}, 2'b00);
    check("mid_rst_opA", md_operandA, 32'h0);
    check("mid_rst_ready", req_ready, 1'b0);
    tick();
    check("post_rst_ready", req_ready, 1'b1);
    tick();
    md_result    = 32'd50;
    md_resultRDY = 1'b1;
    tick();
    md_resultRDY = 1'b0;
    check("stale_rdy_rsp", rsp_valid, 1'b0);
    check("stale_rdy_state", dbg_state, ST_IDLE);
    start_op(OP_DIV, 32'd100, 32'd10, 5'd4);
    finish_op(5, 32'd10, 1'b0, 5'd4);
    release_rsp();

`ifdef MULTDIV_TIMEOUT_EN
    // 6: unit never answers; watchdog completes after 48 WAIT cycles
    start_op(OP_MULT, 32'd3, 32'd3, 5'd1);
    for (int i = 0; i < 48; i++) tick();
    check("to_not_yet", rsp_valid, 1'b0);
    tick();
    check("to_rsp_valid", rsp_valid, 1'b1);
    check("to_rsp_exc", rsp_exception, 1'b1);
    check("to_rsp_result", rsp_result, 32'h0);
    check("to_rsp_tag", rsp_tag, 5'd1);
    release_rsp();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
